// File: rtl/cla_add_scheduler_pkg.sv
// Shared definitions for the carry-lookahead adder scheduler.
//   WordW / DwordW : width of one adder pass and of a full double-word operand.
//   state_e        : scheduler FSM states.
package cla_add_scheduler_pkg;

    localparam int unsigned WordW  = 32;
    localparam int unsigned DwordW = 64;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StResp = 2'd3
    } state_e;

endpackage

// File: rtl/cla_add_scheduler_cla.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
//   a, b : operands
//   cin  : carry-in
//   sum  : a + b + cin modulo 2^32
//   cout : carry-out of bit 31
module cla_add_scheduler_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each group's four carries are expanded directly from the group carry-in.
    always_comb begin
        logic [3:0] gg;
        logic [3:0] pp;
        logic       ci;
        gg   = '0;
        pp   = '0;
        ci   = 1'b0;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gg = g[4*k +: 4];
            pp = p[4*k +: 4];
            ci = c[4*k];
            c[4*k+1] = gg[0] | (pp[0] & ci);
            c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
            c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & ci);
            c[4*k+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0])
                     | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/cla_add_scheduler_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req       : request vector
//   ptr       : highest-priority index for this round
//   grant     : one-hot grant, zero when no request is present
//   grant_idx : index of the granted requester (0 when none)
//   grant_any : at least one request is present
module cla_add_scheduler_rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IdW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IdW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IdW-1:0] grant_idx,
    output logic           grant_any
);

    // Scan circularly starting at ptr; the first set request wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/cla_add_scheduler.sv
// Shares one 32-bit carry-lookahead adder among NUM_REQ requesters.
// Round-robin grant in IDLE; 32-bit adds take one adder pass, 64-bit adds take a low
// pass and a high pass with the carry held in between.
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid / req_ready  : per-requester handshake, req_ready one-hot and only in IDLE
//   req_a, req_b           : 64-bit operands, requester i at [64*i+63:64*i]
//   req_cin, req_w64       : per-requester carry-in and 64-bit select
//   rsp_valid / rsp_ready  : response handshake
//   rsp_id, rsp_sum, rsp_cout : owner, sum, carry-out of the last word computed
module cla_add_scheduler
    import cla_add_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_a,
    input  logic [NUM_REQ*64-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_cin,
    input  logic [NUM_REQ-1:0]    req_w64,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_sum,
    output logic                  rsp_cout
);

    state_e state_q, state_d;

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_next;
    logic [DwordW-1:0] a_q, b_q;
    logic              cin_q, w64_q;
    logic [ID_W-1:0]   id_q;
    logic [WordW-1:0]  sum_lo_q, sum_hi_q;
    logic              carry_lo_q, cout_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               accept;
    logic [DwordW-1:0]  sel_a, sel_b;

    logic [WordW-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;

    cla_add_scheduler_rr_arbiter #(
        .N   (NUM_REQ),
        .IdW (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    cla_add_scheduler_cla u_cla (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept   = (state_q == StIdle) && grant_any;
    assign sel_a    = req_a[DwordW*grant_idx +: DwordW];
    assign sel_b    = req_b[DwordW*grant_idx +: DwordW];
    // Wraps to 0 after the last requester; constant 0 when NUM_REQ is 1.
    assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLo;
            StLo:    state_d = w64_q ? StHi : StResp;
            StHi:    state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs and adder input mux; adder inputs are zero outside LO/HI.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        unique case (state_q)
            StIdle: req_ready = rst ? '0 : grant;
            StLo: begin
                add_a   = a_q[WordW-1:0];
                add_b   = b_q[WordW-1:0];
                add_cin = cin_q;
            end
            StHi: begin
                add_a   = a_q[DwordW-1:WordW];
                add_b   = b_q[DwordW-1:WordW];
                add_cin = carry_lo_q;
            end
            StResp:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand, pointer and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            w64_q      <= 1'b0;
            id_q       <= '0;
            sum_lo_q   <= '0;
            sum_hi_q   <= '0;
            carry_lo_q <= 1'b0;
            cout_q     <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= sel_a;
                b_q      <= sel_b;
                cin_q    <= req_cin[grant_idx];
                w64_q    <= req_w64[grant_idx];
                id_q     <= grant_idx;
                ptr_q    <= ptr_next;
                sum_hi_q <= '0;  // upper word stays zero for 32-bit adds
            end
            if (state_q == StLo) begin
                sum_lo_q   <= add_sum;
                carry_lo_q <= add_cout;
                cout_q     <= add_cout;
            end
            if (state_q == StHi) begin
                sum_hi_q <= add_sum;
                cout_q   <= add_cout;
            end
        end
    end

    assign rsp_id   = id_q;
    assign rsp_sum  = {sum_hi_q, sum_lo_q};
    assign rsp_cout = cout_q;

endmodule

// File: tb/tb_cla_add_scheduler.sv
// Self-checking bench for cla_add_scheduler: directed cases plus randomized traffic,
// checked by a scoreboard fed from a round-robin/arithmetic reference model.
module tb_cla_add_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_cin, req_w64;
    logic [N*64-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [63:0]     rsp_sum;
    logic            rsp_cout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          id;
        logic [63:0] sum;
        logic        cout;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   mptr        = 0;
    bit   busy        = 0;
    bit   seen_valid  = 0;
    int   exp_lat_cyc = 0;

    cla_add_scheduler #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_w64   (req_w64),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Reference arithmetic: plain wide addition of the words that matter.
    function automatic exp_t model_add(input int id, input logic [63:0] a, input logic [63:0] b,
                                       input logic cin, input logic w64);
        exp_t        e;
        logic [64:0] s;
        e.id = id;
        if (w64) begin
            s      = {1'b0, a} + {1'b0, b} + 65'(cin);
            e.sum  = s[63:0];
            e.cout = s[64];
        end else begin
            s      = {33'b0, a[31:0]} + {33'b0, b[31:0]} + 65'(cin);
            e.sum  = {32'b0, s[31:0]};
            e.cout = s[32];
        end
        return e;
    endfunction

    // Reference arbitration: first valid requester at or after the pointer.
    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        int          g;
        logic [N-1:0] er;
        exp_t        e;
        if (rst) begin
            sb.delete();
            busy       = 0;
            seen_valid = 0;
            mptr       = 0;
        end else begin
            if (busy) begin
                check("ready_while_busy", 64'(req_ready), 64'(0));
            end else begin
                g  = model_grant(req_valid, mptr);
                er = '0;
                if (g >= 0) er[g] = 1'b1;
                check("grant", 64'(req_ready), 64'(er));
                if (g >= 0) begin
                    sb.push_back(model_add(g, req_a[64*g +: 64], req_b[64*g +: 64],
                                           req_cin[g], req_w64[g]));
                    grant_log.push_back(g);
                    exp_lat_cyc = cyc + (req_w64[g] ? 3 : 2);
                    busy        = 1;
                    mptr        = (g + 1) % N;
                end
            end
            if (rsp_valid) begin
                if (!seen_valid) check("latency", 64'(cyc), 64'(exp_lat_cyc));
                seen_valid = 1;
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got id %0d sum %h, expected none",
                                 rsp_id, rsp_sum);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", 64'(rsp_id), 64'(e.id));
                        check("rsp_sum", rsp_sum, e.sum);
                        check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
                    end
                    busy       = 0;
                    seen_valid = 0;
                end
            end
        end
    end

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0 && !rsp_valid) ok = 1;
        end
        if (!ok) timeout("drain");
    endtask

    task automatic wait_ready(input int lane, output int acc_cyc);
        bit ok;
        ok      = 0;
        acc_cyc = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[lane]) begin
                ok      = 1;
                acc_cyc = cyc;
            end
        end
        if (!ok) timeout("wait_ready");
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
        if (!ok) timeout("wait_rsp");
    endtask

    // Single request on one lane; operands are scrambled after acceptance.
    task automatic do_one(input int lane, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic w64,
                          input logic [63:0] exp_sum, input logic exp_cout);
        int acc;
        bit ok;
        @(posedge clk); #1;
        req_a[64*lane +: 64] = a;
        req_b[64*lane +: 64] = b;
        req_cin[lane]        = cin;
        req_w64[lane]        = w64;
        req_valid            = '0;
        req_valid[lane]      = 1'b1;
        wait_ready(lane, acc);
        @(posedge clk); #1;
        req_valid            = '0;
        req_a[64*lane +: 64] = {$urandom, $urandom};
        req_b[64*lane +: 64] = {$urandom, $urandom};
        req_cin[lane]        = ~cin;
        wait_rsp(ok);
        if (ok) begin
            check("dir_latency", 64'(cyc - acc), w64 ? 64'd3 : 64'd2);
            check("dir_sum", rsp_sum, exp_sum);
            check("dir_cout", 64'(rsp_cout), 64'(exp_cout));
            check("dir_id", 64'(rsp_id), 64'(lane));
        end
        drain();
    endtask

    initial begin
        int   acc;
        bit   ok;
        exp_t e;

        rst       = 1'b1;
        req_valid = 4'b0001;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_w64   = '0;
        rsp_ready = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_sum", rsp_sum, 64'(0));
        check("rst_rsp_cout", 64'(rsp_cout), 64'(0));
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Test 4: all requesters valid, ids as operands -> strict rotation from 0
        grant_log.delete();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            req_a[64*i +: 64] = 64'(i);
            req_b[64*i +: 64] = 64'(i);
        end
        req_valid = '1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (grant_log.size() >= 8) ok = 1;
        end
        if (!ok) timeout("rotation");
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            check("rotation_order", 64'(grant_log[k]), 64'(k % N));
        end
        drain();

        // Tests 1-3
        do_one(0, 64'h0000_0001_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0, 1'b1);
        do_one(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 1'b0);
        do_one(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // Test 5: response back-pressure holds outputs and blocks new grants
        @(posedge clk); #1;
        rsp_ready          = 1'b0;
        req_a[63:0]        = 64'h1234_5678_9ABC_DEF0;
        req_b[63:0]        = 64'h1111_1111_8765_4321;
        req_cin[0]         = 1'b1;
        req_w64[0]         = 1'b0;
        e                  = model_add(0, req_a[63:0], req_b[63:0], 1'b1, 1'b0);
        req_valid          = 4'b0001;
        wait_ready(0, acc);
        @(posedge clk); #1;
        req_valid = 4'b0110;
        wait_rsp(ok);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(rsp_valid), 64'(1));
            check("hold_sum", rsp_sum, e.sum);
            check("hold_cout", 64'(rsp_cout), 64'(e.cout));
            check("hold_id", 64'(rsp_id), 64'(0));
            check("hold_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_valid", 64'(rsp_valid), 64'(0));
        check("release_grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Test 6: reset during the high pass discards the operation
        @(posedge clk); #1;
        req_a[64*2 +: 64] = 64'h0000_0005_0000_0007;
        req_b[64*2 +: 64] = 64'h0000_0003_0000_0009;
        req_cin[2]        = 1'b0;
        req_w64[2]        = 1'b1;
        req_valid         = 4'b0100;
        wait_ready(2, acc);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = 4'b1010;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_rsp_id", 64'(rsp_id), 64'(0));
        check("midrst_rsp_sum", rsp_sum, 64'(0));
        check("midrst_rsp_cout", 64'(rsp_cout), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("postrst_grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req_valid = N'($urandom);
            req_cin   = N'($urandom);
            req_w64   = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[64*i +: 64] = {$urandom, $urandom};
                req_b[64*i +: 64] = {$urandom, $urandom};
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
